// File: rtl/alu_pkg.sv
// Shared types, constants and operand-requirement decode for the ALU execution core.
package alu_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned C_W      = 4;
    localparam int unsigned WAIT_CYC = 16;

    typedef enum logic [C_W-1:0] {
        CmdAdd, CmdSub, CmdAddCin, CmdSubCin, CmdIncA, CmdDecA, CmdIncB, CmdDecB,
        CmdCmp, CmdMulInc, CmdMulShl
    } arith_cmd_e;

    typedef enum logic [C_W-1:0] {
        LogAnd, LogNand, LogOr, LogNor, LogXor, LogXnor, LogNotA, LogNotB,
        LogShrA, LogShlA, LogShrB, LogShlB, LogRol, LogRor
    } logic_cmd_e;

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, MUL} state_e;

    // bit0 = OPA needed, bit1 = OPB needed; 2'b00 marks an invalid command
    function automatic logic [1:0] needs_ops(input logic mode, input logic [C_W-1:0] cmd);
        logic [1:0] need;
        need = 2'b00;
        if (mode) begin
            case (cmd)
                CmdIncA, CmdDecA: need = 2'b01;
                CmdIncB, CmdDecB: need = 2'b10;
                CmdAdd, CmdSub, CmdAddCin, CmdSubCin, CmdCmp, CmdMulInc, CmdMulShl: need = 2'b11;
                default: need = 2'b00;
            endcase
        end else begin
            case (cmd)
                LogNotA, LogShrA, LogShlA: need = 2'b01;
                LogNotB, LogShrB, LogShlB: need = 2'b10;
                LogAnd, LogNand, LogOr, LogNor, LogXor, LogXnor, LogRol, LogRor: need = 2'b11;
                default: need = 2'b00;
            endcase
        end
        return need;
    endfunction

    function automatic logic is_mul(input logic mode, input logic [C_W-1:0] cmd);
        return mode && (cmd == CmdMulInc || cmd == CmdMulShl);
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU datapath: produces RES and every flag from latched operands and command.
module alu_compute #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic                    mode_i,
    input  logic [alu_pkg::C_W-1:0] cmd_i,
    input  logic [WIDTH-1:0]        a_i,
    input  logic [WIDTH-1:0]        b_i,
    input  logic                    cin_i,
    output logic [WIDTH:0]          res_o,
    output logic                    cout_o,
    output logic                    oflow_o,
    output logic                    g_o,
    output logic                    l_o,
    output logic                    e_o,
    output logic                    err_o
);
    import alu_pkg::*;

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH + 2;

    logic [WIDTH:0]     a_ext, b_ext, cin_ext, sum, diff;
    logic [PW-1:0]      prod;
    logic [2*WIDTH-1:0] rol_full, ror_full;
    logic [ShW-1:0]     rot_amt;
    logic               rot_range_err;

    always_comb begin
        a_ext         = {1'b0, a_i};
        b_ext         = {1'b0, b_i};
        cin_ext       = {{WIDTH{1'b0}}, cin_i};
        rot_amt       = b_i[ShW-1:0];
        rot_range_err = |b_i[WIDTH-1:ShW];
        // Rotating a doubled copy keeps the wrapped bits without a variable-width shift
        rol_full      = {a_i, a_i} << rot_amt;
        ror_full      = {a_i, a_i} >> rot_amt;
        sum           = '0;
        diff          = '0;
        prod          = '0;
        res_o         = '0;
        cout_o        = 1'b0;
        oflow_o       = 1'b0;
        g_o           = 1'b0;
        l_o           = 1'b0;
        e_o           = 1'b0;
        err_o         = 1'b0;
        if (mode_i) begin
            case (cmd_i)
                CmdAdd, CmdAddCin, CmdIncA, CmdIncB: begin
                    case (cmd_i)
                        CmdAdd:    sum = a_ext + b_ext;
                        CmdAddCin: sum = a_ext + b_ext + cin_ext;
                        CmdIncA:   sum = a_ext + (WIDTH+1)'(1);
                        default:   sum = b_ext + (WIDTH+1)'(1);
                    endcase
                    res_o  = sum;
                    cout_o = sum[WIDTH];
                end
                CmdSub, CmdSubCin, CmdDecA, CmdDecB: begin
                    case (cmd_i)
                        CmdSub:    diff = a_ext - b_ext;
                        CmdSubCin: diff = a_ext - b_ext - cin_ext;
                        CmdDecA:   diff = a_ext - (WIDTH+1)'(1);
                        default:   diff = b_ext - (WIDTH+1)'(1);
                    endcase
                    res_o   = {1'b0, diff[WIDTH-1:0]};
                    oflow_o = diff[WIDTH];
                end
                CmdCmp: begin
                    g_o = (a_i > b_i);
                    l_o = (a_i < b_i);
                    e_o = (a_i == b_i);
                end
                CmdMulInc, CmdMulShl: begin
                    if (cmd_i == CmdMulInc) prod = PW'(a_ext + 1'b1) * PW'(b_ext + 1'b1);
                    else                    prod = PW'({a_i, 1'b0}) * PW'(b_i);
                    res_o   = prod[WIDTH:0];
                    oflow_o = |prod[PW-1:WIDTH+1];
                end
                default: err_o = 1'b1;
            endcase
        end else begin
            case (cmd_i)
                LogAnd:  res_o = {1'b0, a_i & b_i};
                LogNand: res_o = {1'b0, ~(a_i & b_i)};
                LogOr:   res_o = {1'b0, a_i | b_i};
                LogNor:  res_o = {1'b0, ~(a_i | b_i)};
                LogXor:  res_o = {1'b0, a_i ^ b_i};
                LogXnor: res_o = {1'b0, ~(a_i ^ b_i)};
                LogNotA: res_o = {1'b0, ~a_i};
                LogNotB: res_o = {1'b0, ~b_i};
                LogShrA: res_o = {1'b0, a_i >> 1};
                LogShlA: res_o = {1'b0, a_i << 1};
                LogShrB: res_o = {1'b0, b_i >> 1};
                LogShlB: res_o = {1'b0, b_i << 1};
                LogRol: begin
                    res_o = {1'b0, rol_full[2*WIDTH-1:WIDTH]};
                    err_o = rot_range_err;
                end
                LogRor: begin
                    res_o = {1'b0, ror_full[WIDTH-1:0]};
                    err_o = rot_range_err;
                end
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_core.sv
// ALU responder: collects split operands, sequences EXEC/MUL, and registers every result output.
module alu_exec_core #(
    parameter int unsigned WIDTH    = alu_pkg::WIDTH,
    parameter int unsigned C_W      = alu_pkg::C_W,
    parameter int unsigned WAIT_CYC = alu_pkg::WAIT_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             MODE,
    input  logic [C_W-1:0]   CMD,
    input  logic [1:0]       INP_VALID,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic             CIN,
    output logic [WIDTH:0]   RES,
    output logic             COUT,
    output logic             OFLOW,
    output logic             G,
    output logic             L,
    output logic             E,
    output logic             ERR
);
    import alu_pkg::*;

    localparam int unsigned CntW = $clog2(WAIT_CYC + 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [C_W-1:0]   cmd_q, cmd_d;
    logic             mode_q, mode_d, cin_q, cin_d;
    logic [1:0]       have_q, have_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             cout_q, cout_d, oflow_q, oflow_d, g_q, g_d, l_q, l_d, e_q, e_d;
    logic             err_q, err_d;

    logic [1:0]       need_in, got_in, missing;
    logic [WIDTH:0]   c_res;
    logic             c_cout, c_oflow, c_g, c_l, c_e, c_err;

    alu_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .mode_i  (mode_q),
        .cmd_i   (cmd_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .cin_i   (cin_q),
        .res_o   (c_res),
        .cout_o  (c_cout),
        .oflow_o (c_oflow),
        .g_o     (c_g),
        .l_o     (c_l),
        .e_o     (c_e),
        .err_o   (c_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        have_d  = have_q;
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        err_d   = err_q;
        need_in = needs_ops(MODE, CMD);
        got_in  = INP_VALID & need_in;
        missing = needs_ops(mode_q, cmd_q) & ~have_q;
        case (state_q)
            IDLE: begin
                if (INP_VALID != 2'b00) begin
                    if (need_in == 2'b00) begin
                        {res_d, cout_d, oflow_d, g_d, l_d, e_d} = '0;
                        err_d = 1'b1;
                    end else if (got_in != 2'b00) begin
                        if (got_in[0]) a_d = OPA;
                        if (got_in[1]) b_d = OPB;
                        cmd_d  = CMD;
                        mode_d = MODE;
                        cin_d  = CIN;
                        have_d = got_in;
                        if (got_in == need_in) begin
                            state_d = is_mul(MODE, CMD) ? MUL : EXEC;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
            end
            WAIT: begin
                // Only the missing operand is taken; command fields stay as first latched
                if ((INP_VALID & missing) != 2'b00) begin
                    if (missing[0]) a_d = OPA;
                    if (missing[1]) b_d = OPB;
                    have_d  = have_q | missing;
                    cnt_d   = '0;
                    state_d = is_mul(mode_q, cmd_q) ? MUL : EXEC;
                end else if (cnt_q == CntW'(WAIT_CYC)) begin
                    {res_d, cout_d, oflow_d, g_d, l_d, e_d} = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUL: state_d = EXEC;
            EXEC: begin
                res_d   = c_res;
                cout_d  = c_cout;
                oflow_d = c_oflow;
                g_d     = c_g;
                l_d     = c_l;
                e_d     = c_e;
                err_d   = c_err;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            have_q  <= 2'b00;
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
        end else if (CE) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            have_q  <= have_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign RES   = res_q;
    assign COUT  = cout_q;
    assign OFLOW = oflow_q;
    assign G     = g_q;
    assign L     = l_q;
    assign E     = e_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_alu_exec_core.sv
// Randomized self-checking bench for alu_exec_core against a transaction-level reference model.
module tb_alu_exec_core;

    localparam int WAIT_CYC = 16;

    logic       CLK = 1'b0;
    logic       RST, CE, MODE, CIN;
    logic [3:0] CMD;
    logic [1:0] INP_VALID;
    logic [7:0] OPA, OPB;
    logic [8:0] RES;
    logic       COUT, OFLOW, G, L, E, ERR;

    logic [14:0] dut_out, prev;
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    assign dut_out = {RES, COUT, OFLOW, G, L, E, ERR};

    alu_exec_core dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .MODE      (MODE),
        .CMD       (CMD),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .L         (L),
        .E         (E),
        .ERR       (ERR)
    );

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h flags(c,o,g,l,e,err)=%b expected res=%h flags=%b",
                     tag, got[14:6], got[5:0], exp[14:6], exp[5:0]);
        end
    endtask

    // Expected {RES, COUT, OFLOW, G, L, E, ERR} for one completed command
    function automatic logic [14:0] ref_out(input bit mode, input int cmd, input int a,
                                            input int b, input int cin);
        int r, p;
        bit co, of, gt, lt, eq, er;
        r = 0; p = 0; co = 0; of = 0; gt = 0; lt = 0; eq = 0; er = 0;
        if (mode) begin
            case (cmd)
                0:  begin r = a + b;               co = (r > 255); end
                1:  begin r = (a - b) & 255;       of = (a < b); end
                2:  begin r = a + b + cin;         co = (r > 255); end
                3:  begin r = (a - b - cin) & 255; of = (a < b + cin); end
                4:  begin r = a + 1;               co = (r > 255); end
                5:  begin r = (a - 1) & 255;       of = (a == 0); end
                6:  begin r = b + 1;               co = (r > 255); end
                7:  begin r = (b - 1) & 255;       of = (b == 0); end
                8:  begin gt = (a > b); lt = (a < b); eq = (a == b); end
                9:  begin p = (a + 1) * (b + 1);   r = p % 512; of = (p >= 512); end
                10: begin p = 2 * a * b;           r = p % 512; of = (p >= 512); end
                default: er = 1;
            endcase
        end else begin
            case (cmd)
                0:  r = a & b;
                1:  r = 255 - (a & b);
                2:  r = a | b;
                3:  r = 255 - (a | b);
                4:  r = a ^ b;
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  r = a / 2;
                9:  r = (a * 2) % 256;
                10: r = b / 2;
                11: r = (b * 2) % 256;
                12, 13: begin
                    r = a;
                    for (int i = 0; i < b % 8; i++) begin
                        if (cmd == 12) r = (r * 2) % 256 + r / 128;
                        else           r = r / 2 + (r % 2) * 128;
                    end
                    er = (b > 7);
                end
                default: er = 1;
            endcase
        end
        return {9'(r), co, of, gt, lt, eq, er};
    endfunction

    // 1 = A only, 2 = B only, 3 = both, 0 = invalid command
    function automatic int ref_need(input bit mode, input int cmd);
        if (mode) begin
            if (cmd == 4 || cmd == 5) return 1;
            if (cmd == 6 || cmd == 7) return 2;
            if (cmd <= 10) return 3;
        end else begin
            if (cmd == 6 || cmd == 8 || cmd == 9) return 1;
            if (cmd == 7 || cmd == 10 || cmd == 11) return 2;
            if (cmd <= 13) return 3;
        end
        return 0;
    endfunction

    task automatic step(input bit ce, input bit mode, input logic [3:0] cmd, input logic [1:0] iv,
                        input logic [7:0] a, input logic [7:0] b, input bit cin);
        CE = ce; MODE = mode; CMD = cmd; INP_VALID = iv; OPA = a; OPB = b; CIN = cin;
        @(posedge CLK);
        #1;
    endtask

    task automatic junk_step(input bit ce, input logic [1:0] iv);
        step(ce, 1'($urandom), 4'($urandom), iv, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // style: 0 both operands at once, 1 A first, 2 B first, 3 A first then timeout
    task automatic run_txn(input string tag, input bit mode, input int cmd, input int a, input int b,
                           input bit cin, input int style, input int gap, input int holes,
                           input bit use_lit, input logic [14:0] lit);
        logic [14:0] exp;
        logic [1:0]  iv;
        int          need, lat;
        need = ref_need(mode, cmd);
        exp  = use_lit ? lit : ref_out(mode, cmd, a, b, cin);
        lat  = (mode && (cmd == 9 || cmd == 10)) ? 2 : 1;
        if (need == 0) begin
            step(1'b1, mode, 4'(cmd), 2'($urandom_range(3, 1)), 8'(a), 8'(b), cin);
            check_eq({tag, "_inv"}, dut_out, exp);
            prev = exp;
            return;
        end
        if (style == 0) begin
            iv = 2'(need) | 2'($urandom_range(3, 0));
            step(1'b1, mode, 4'(cmd), iv, 8'(a), 8'(b), cin);
            check_eq({tag, "_cap"}, dut_out, prev);
        end else begin
            if (style == 2) step(1'b1, mode, 4'(cmd), 2'b10, 8'($urandom), 8'(b), cin);
            else            step(1'b1, mode, 4'(cmd), 2'b01, 8'(a), 8'($urandom), cin);
            check_eq({tag, "_first"}, dut_out, prev);
            for (int i = 0; i < holes; i++) begin
                junk_step(1'b0, 2'($urandom));
                check_eq({tag, "_hole"}, dut_out, prev);
            end
            for (int i = 1; i <= gap; i++) begin
                junk_step(1'b1, 2'b00);
                if (style == 3 && i == gap) check_eq({tag, "_tmo"}, dut_out, 15'h001);
                else                        check_eq({tag, "_wait"}, dut_out, prev);
            end
            if (style == 3) begin
                prev = 15'h001;
                return;
            end
            // Present operand re-driven with junk, plus junk command fields
            if (style == 2) begin
                iv = 2'b01 | {1'($urandom), 1'b0};
                step(1'b1, 1'($urandom), 4'($urandom), iv, 8'(a), 8'($urandom), 1'($urandom));
            end else begin
                iv = 2'b10 | {1'b0, 1'($urandom)};
                step(1'b1, 1'($urandom), 4'($urandom), iv, 8'($urandom), 8'(b), 1'($urandom));
            end
            check_eq({tag, "_second"}, dut_out, prev);
        end
        for (int k = 1; k <= lat; k++) begin
            if ($urandom_range(3, 0) == 0) begin
                junk_step(1'b0, 2'($urandom));
                check_eq({tag, "_freeze"}, dut_out, prev);
            end
            junk_step(1'b1, 2'($urandom));
            if (k < lat) check_eq({tag, "_mul"}, dut_out, prev);
            else         check_eq({tag, "_res"}, dut_out, exp);
        end
        prev = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  mode, cmd, a, b, cin, need, style, gap, holes, sel;
        RST = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0;
        OPA = '0; OPB = '0; CIN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset", dut_out, 15'h000);
        RST  = 1'b0;
        prev = 15'h000;

        run_txn("tp_add", 1, 0, 'hFF, 'h01, 0, 0, 0, 0, 1, {9'h100, 1'b1, 5'b0});
        run_txn("tp_sub", 1, 1, 'h05, 'h07, 0, 0, 0, 0, 1, {9'h0FE, 1'b0, 1'b1, 4'b0});
        run_txn("tp_cmp", 1, 8, 'h33, 'h33, 0, 0, 0, 0, 1, {9'h000, 4'b0, 1'b1, 1'b0});
        run_txn("tp_mul", 1, 9, 3, 4, 0, 0, 0, 0, 1, {9'd20, 6'b0});
        run_txn("tp_split", 1, 0, 10, 20, 0, 1, 5, 0, 1, {9'd30, 6'b0});
        run_txn("tp_tmo", 1, 0, 10, 20, 0, 3, WAIT_CYC, 0, 1, 15'h001);
        run_txn("tp_after", 1, 0, 1, 2, 0, 0, 0, 0, 1, {9'd3, 6'b0});
        run_txn("tp_rol_err", 0, 12, 'h81, 'h11, 0, 0, 0, 0, 1, {9'h003, 5'b0, 1'b1});
        run_txn("tp_tmo_ce", 1, 1, 7, 9, 0, 3, WAIT_CYC, 3, 1, 15'h001);
        run_txn("tp_rol", 0, 12, 'h81, 'h01, 0, 0, 0, 0, 1, {9'h003, 6'b0});

        // Reset while waiting for a second operand
        step(1'b1, 1'b1, 4'd0, 2'b01, 8'h11, 8'h00, 1'b0);
        repeat (3) junk_step(1'b1, 2'b00);
        RST = 1'b1;
        junk_step(1'b0, 2'b11);
        check_eq("rst_wait", dut_out, 15'h000);
        RST  = 1'b0;
        prev = 15'h000;
        for (int i = 0; i < WAIT_CYC + 4; i++) begin
            junk_step(1'b1, 2'b00);
            check_eq("rst_wait_idle", dut_out, 15'h000);
        end

        run_txn("tp_arith_rol", 1, 12, 'h81, 'h01, 0, 0, 0, 0, 1, 15'h001);
        run_txn("pre_rst_mul", 1, 0, 'h40, 'h02, 0, 0, 0, 0, 1, {9'h042, 6'b0});

        // Reset while the multiply stage is in flight
        step(1'b1, 1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
        RST = 1'b1;
        junk_step(1'b1, 2'b00);
        check_eq("rst_mul", dut_out, 15'h000);
        RST  = 1'b0;
        prev = 15'h000;
        for (int i = 0; i < 3; i++) begin
            junk_step(1'b1, 2'b00);
            check_eq("rst_mul_idle", dut_out, 15'h000);
        end

        for (int n = 0; n < 250; n++) begin
            mode = int'($urandom_range(1, 0));
            cmd  = int'($urandom_range(15, 0));
            a    = int'($urandom_range(255, 0));
            b    = int'($urandom_range(255, 0));
            cin  = int'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1) b = b % 8;
            need  = ref_need(mode[0], cmd);
            style = 0;
            if (need == 3) begin
                sel   = int'($urandom_range(7, 0));
                style = (sel < 4) ? 0 : (sel < 6) ? 1 : (sel == 6) ? 2 : 3;
            end
            gap   = (style == 3) ? WAIT_CYC : int'($urandom_range(14, 0));
            holes = (style == 0) ? 0 : int'($urandom_range(2, 0));
            run_txn("rnd", mode[0], cmd, a, b, cin[0], style, gap, holes, 1'b0, 15'h000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_core.md
Name: alu_exec_core

Overview:
Responder end of the ALU stimulus interface. It accepts OPA/OPB/CMD/CE/CIN/MODE/INP_VALID, collects operands that arrive in separate cycles, and executes arithmetic (MODE=1) or logic (MODE=0) commands. It returns registered RES/COUT/OFLOW/G/L/E/ERR. It is the DUT behind the driver/monitor clocking blocks.

Parameters:
WIDTH, 8, operand width
C_W, 4, command width
WAIT_CYC, 16, max CE-active cycles waited for a missing second operand

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
CE  in  1  clock enable; 0 freezes all state and outputs
MODE  in  1  1=arithmetic, 0=logic
CMD  in  C_W  command
INP_VALID  in  2  bit0=OPA valid, bit1=OPB valid
OPA, OPB  in  WIDTH  operands
CIN  in  1  carry-in
RES  out  WIDTH+1  result
COUT, OFLOW, G, L, E, ERR  out  1  flags

Behaviour:
- Interface rule: one clock, CLK; reset RST is synchronous and active-high.
- Reset: on RST=1 at a posedge, all outputs go to 0, the FSM goes to IDLE, and the wait counter clears. RST overrides CE and any in-flight operation.
- CE=0: no state, counter or output changes.

Commands, MODE=1:
- 0 ADD; 1 SUB; 2 ADD_CIN; 3 SUB_CIN; 4 INC_A; 5 DEC_A; 6 INC_B; 7 DEC_B; 8 CMP.
- 9: (A+1)*(B+1).
- 10: (A<<1)*B.
- 11-15: ERR.

Commands, MODE=0:
- 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR; 6 NOT_A; 7 NOT_B; 8 SHR1_A; 9 SHL1_A; 10 SHR1_B; 11 SHL1_B; 12 ROL A by B; 13 ROR A by B.
- 14-15: ERR.
- Logic results are zero-extended. NOT and shift results are WIDTH bits with RES[WIDTH]=0.

Operand requirements:
- A-only: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
- B-only: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
- All other valid commands need both operands.

Arithmetic rules:
- ADD/ADD_CIN/INC: RES = full WIDTH+1 sum; COUT = RES[WIDTH].
- SUB/SUB_CIN/DEC: RES[WIDTH-1:0] = difference (SUB_CIN subtracts CIN as well); RES[WIDTH]=0; OFLOW = unsigned borrow.
- CMP: RES=0; exactly one of G/L/E set (A>B, A<B, A==B).
- MUL: RES = product[WIDTH:0]; OFLOW=1 if any higher product bit is nonzero.
- ROL/ROR: amount = OPB[$clog2(WIDTH)-1:0]. If any higher OPB bit is 1, ERR=1 and RES still holds the rotated value.
- Each result update writes every output; flags not defined for the command are 0.
- Invalid command: next update gives ERR=1 and all other outputs 0.

FSM:
- IDLE, CE=1:
  - INP_VALID=00: hold.
  - Invalid CMD: update next edge with ERR.
  - Required operands present: latch operands and go to EXEC (MUL for commands 9/10 in MODE=1).
  - Two-operand command with INP_VALID 01 or 10: latch the present operand plus CMD/MODE/CIN, set cnt=1, go to WAIT.
- WAIT, CE=1:
  - Missing operand's valid bit =1: latch it and go to EXEC/MUL. New CMD/MODE/CIN on that cycle are ignored; a re-driven present operand is also ignored.
  - Else cnt++.
  - cnt reaches WAIT_CYC: next edge gives ERR=1, RES=0, and the FSM returns to IDLE.
- EXEC: outputs update, then IDLE. This is the cycle after the capture edge; the capture-to-RES latency is 1 cycle.
- MUL: one extra stage; the capture-to-RES latency is 2 cycles. Inputs are ignored during MUL.
- A new command is accepted only in IDLE; inputs in EXEC/MUL are dropped.

Decomposition:
- Package alu_pkg holds:
  - typedefs: arith_cmd_e and logic_cmd_e enums; state_e {IDLE, WAIT, EXEC, MUL}.
  - constants WIDTH, C_W, WAIT_CYC.
  - function needs_ops(mode, cmd), returning 2-bit operand need.
- Sub-module alu_compute: combinational datapath taking latched operands/cmd/mode/cin and returning RES and flags. alu_exec_core holds the FSM, counter, operand latches and output registers.

Test Plan:
- MODE=1 CMD=0, A=0xFF, B=0x01, INP_VALID=11 -> next cycle RES=0x100, COUT=1, ERR=0.
- MODE=1 CMD=1, A=0x05, B=0x07 -> RES=0x0FE, OFLOW=1; CMD=8 with A=B=0x33 -> E=1, G=L=0, RES=0.
- MODE=1 CMD=9, A=3, B=4 -> RES=20 exactly 2 cycles after capture; inputs driven in the MUL cycle are dropped.
- MODE=1 CMD=0, INP_VALID=01 A=10; 5 cycles of 00; then INP_VALID=10 B=20 with CMD=5 -> RES=30 (CMD=5 ignored). Repeat with 16 cycles of 00 -> ERR=1, RES=0; then IDLE accepts a new command.
- MODE=0 CMD=12, A=0x81, B=0x11 -> RES=0x003, ERR=1; B=0x01 -> RES=0x003, ERR=0. MODE=1 CMD=12 -> ERR=1.
- RST=1 mid-WAIT and mid-MUL -> all outputs 0 next edge, no stale result afterwards. CE=0 for 3 cycles in WAIT -> counter frozen and the timeout shifts by 3.
